// File: rtl/sprite_pkg.sv
// sprite_pkg: shared FSM state type and screen/colour defaults for the sprite blitter
package sprite_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  localparam int DEF_COLOUR_W = 9;
  localparam logic [DEF_COLOUR_W-1:0] DEF_TRANSPARENT = 9'h1FF;
endpackage

// File: rtl/sprite_scan_counter.sv
// sprite_scan_counter: row-major col/row scan with linear ROM address and last-pixel flag
// ports: clock/resetn, clr (restart at pixel 0), en (advance one pixel),
//        col/row (current pixel), addr (row*W+col), last (addr is the final pixel)
module sprite_scan_counter #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int ADDR_W = 8,
  parameter int CW = 4,
  parameter int RW = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              en,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic wrap;
  assign wrap = col == CW'(SPRITE_W - 1);
  assign last = addr == ADDR_W'(SPRITE_W * SPRITE_H - 1);
  // the address is kept as a running count, which equals row*SPRITE_W+col in row-major order
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      col <= '0;
      row <= '0;
      addr <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
      addr <= '0;
    end else if (en) begin
      col <= wrap ? '0 : col + 1'b1;
      row <= wrap ? row + 1'b1 : row;
      addr <= addr + 1'b1;
    end
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: streams a sprite from a synchronous ROM into the vga_adapter plot interface
// ports: clock/resetn, start + x_origin/y_origin (blit request), busy/done (status),
//        rom_addr/rom_data (sprite ROM, 1-cycle read latency),
//        vga_x/vga_y/vga_colour/vga_plot (plot stream, transparent/off-screen pixels suppressed)
module sprite_blitter import sprite_pkg::*; #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int ADDR_W = 8,
  parameter int COLOUR_W = DEF_COLOUR_W,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = DEF_TRANSPARENT,
  parameter bit USE_KEY = 1'b1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x_origin,
  input  logic [Y_W-1:0]      y_origin,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  localparam int CW = SPRITE_W > 1 ? $clog2(SPRITE_W) : 1;
  localparam int RW = SPRITE_H > 1 ? $clog2(SPRITE_H) : 1;
  state_t state;
  logic dcnt, last, accept, s1_issued;
  logic [X_W-1:0] ox;
  logic [Y_W-1:0] oy;
  logic [CW-1:0] col, s1_col;
  logic [RW-1:0] row, s1_row;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  assign accept = start && (state == IDLE || state == DONE);
  sprite_scan_counter #(
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ADDR_W(ADDR_W), .CW(CW), .RW(RW)
  ) u_cnt (
    .clock(clock), .resetn(resetn), .clr(accept), .en(state == SCAN && !last),
    .col(col), .row(row), .addr(rom_addr), .last(last)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      dcnt <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      ox <= '0;
      oy <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state <= SCAN;
        busy <= 1'b1;
        ox <= x_origin;
        oy <= y_origin;
      end else if (state == SCAN && last) begin
        state <= DRAIN;
        dcnt <= 1'b0;
      end else if (state == DRAIN) begin
        dcnt <= 1'b1;
        if (dcnt) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (state == DONE)
        state <= IDLE;
    end
  // stage 1: tag travels with the address while the ROM performs its read
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      s1_issued <= 1'b0;
      s1_col <= '0;
      s1_row <= '0;
    end else begin
      s1_issued <= state == SCAN;
      s1_col <= col;
      s1_row <= row;
    end
  // one extra bit so coordinates past the screen edge cannot wrap back on-screen
  assign px = (X_W+1)'(ox) + (X_W+1)'(s1_col);
  assign py = (Y_W+1)'(oy) + (Y_W+1)'(s1_row);
  // stage 2: clip and colour-key against the ROM word now on rom_data
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
    end else begin
      vga_plot <= s1_issued && px < (X_W+1)'(SCREEN_W) && py < (Y_W+1)'(SCREEN_H) &&
                  !(USE_KEY && rom_data == TRANSPARENT);
      if (s1_issued) begin
        vga_x <= px[X_W-1:0];
        vga_y <= py[Y_W-1:0];
        vga_colour <= rom_data;
      end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: scoreboard bench for sprite_blitter (keyed, unkeyed and 1x1 instances)
module tb_sprite_blitter;
  logic clock = 0;
  always #5 clock = ~clock;
  logic resetn = 0, start = 0, start3 = 0;
  logic [8:0] x_origin = 0;
  logic [7:0] y_origin = 0;
  logic busy, done, vga_plot, busy2, done2, vga_plot2, busy3, done3, vga_plot3;
  logic [7:0] rom_addr, rom_addr2, rom_addr3, vga_y, vga_y2, vga_y3;
  logic [8:0] rom_data, rom_data2, rom_data3, vga_x, vga_x2, vga_x3;
  logic [8:0] vga_colour, vga_colour2, vga_colour3;
  logic [8:0] rom [256];
  always @(posedge clock) begin
    rom_data <= rom[rom_addr];
    rom_data2 <= rom[rom_addr2];
    rom_data3 <= rom_addr3 == 8'd0 ? 9'h05A : 9'h000;
  end
  sprite_blitter dut (
    .clock(clock), .resetn(resetn), .start(start), .x_origin(x_origin), .y_origin(y_origin),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );
  sprite_blitter #(.USE_KEY(1'b0)) dut2 (
    .clock(clock), .resetn(resetn), .start(start), .x_origin(x_origin), .y_origin(y_origin),
    .busy(busy2), .done(done2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .vga_x(vga_x2), .vga_y(vga_y2), .vga_colour(vga_colour2), .vga_plot(vga_plot2)
  );
  sprite_blitter #(.SPRITE_W(1), .SPRITE_H(1)) dut3 (
    .clock(clock), .resetn(resetn), .start(start3), .x_origin(9'd0), .y_origin(8'd0),
    .busy(busy3), .done(done3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .vga_x(vga_x3), .vga_y(vga_y3), .vga_colour(vga_colour3), .vga_plot(vga_plot3)
  );
  int checks = 0, errors = 0, done_cnt = 0, plot_cnt = 0, plot2_cnt = 0, busy_cnt = 0, first_bc = 0;
  bit busy_q = 0, first_seen = 0;
  logic [25:0] q[$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic load_rom(input int key);
    for (int a = 0; a < 256; a++) rom[a] = (key != 0 && a % 2 == 0) ? 9'h1FF : 9'(a);
  endtask
  task automatic push_blit(input int ox, input int oy);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        logic [8:0] w;
        int px, py;
        w = rom[r*16+c];
        px = ox + c;
        py = oy + r;
        if (px < 320 && py < 240 && w != 9'h1FF) q.push_back({9'(px), 8'(py), w});
      end
  endtask
  task automatic kick(input int ox, input int oy);
    #1 start = 1;
    x_origin = 9'(ox);
    y_origin = 8'(oy);
    push_blit(ox, oy);
    plot_cnt = 0;
    plot2_cnt = 0;
    @(negedge clock);
    chk("busy_after_start", busy, 1);
    #1 start = 0;
  endtask
  task automatic wait_done(input int budget);
    bit f = 0;
    for (int i = 0; i < budget && !f; i++) begin
      @(negedge clock);
      f = done;
    end
    if (!f) chk("done_timeout", 0, 1);
  endtask
  initial forever begin
    @(negedge clock);
    if (!resetn) begin
      busy_cnt = 0;
      busy_q = 0;
      first_seen = 0;
    end else begin
      if (busy) busy_cnt++;
      if (busy && !busy_q) begin
        chk("first_addr", rom_addr, 0);
        first_seen = 0;
      end
      if (vga_plot) begin
        plot_cnt++;
        if (!first_seen) first_bc = busy_cnt;
        first_seen = 1;
        if (q.size() == 0) chk("unexpected_plot", 1, 0);
        else chk("pixel_xyc", {vga_x, vga_y, vga_colour}, q.pop_front());
      end
      if (vga_plot2) plot2_cnt++;
      if (done) begin
        done_cnt++;
        chk("busy_len", busy_cnt, 258);
        chk("busy_at_done", busy, 0);
        chk("done_dut2", done2, 1);
        chk("left_in_queue", q.size(), 0);
        busy_cnt = 0;
      end
      busy_q = busy;
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [4:0] eb, ep, ed;
    eb = 5'b00111;
    ep = 5'b00100;
    ed = 5'b01000;
    load_rom(0);
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_plot", vga_plot, 0);
    chk("reset_addr", rom_addr, 0);
    #1 resetn = 1;
    @(negedge clock);
    kick(10, 20);
    wait_done(400);
    chk("plots_basic", plot_cnt, 256);
    chk("first_plot_latency", first_bc, 3);
    chk("done_count_1", done_cnt, 1);
    load_rom(1);
    repeat (2) @(negedge clock);
    kick(10, 20);
    wait_done(400);
    chk("plots_keyed", plot_cnt, 128);
    chk("plots_unkeyed", plot2_cnt, 256);
    load_rom(0);
    repeat (2) @(negedge clock);
    kick(312, 236);
    wait_done(400);
    chk("plots_clipped", plot_cnt, 32);
    chk("done_count_3", done_cnt, 3);
    repeat (2) @(negedge clock);
    kick(40, 50);
    repeat (4) @(negedge clock);
    #1 start = 1;
    x_origin = 0;
    y_origin = 0;
    @(negedge clock);
    #1 start = 0;
    repeat (94) @(negedge clock);
    #1 start = 1;
    @(negedge clock);
    #1 start = 0;
    wait_done(400);
    chk("plots_repulse", plot_cnt, 256);
    chk("done_count_4", done_cnt, 4);
    kick(100, 100);
    wait_done(400);
    chk("plots_done_restart", plot_cnt, 256);
    chk("done_count_5", done_cnt, 5);
    repeat (2) @(negedge clock);
    kick(10, 20);
    repeat (37) @(negedge clock);
    #1 resetn = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", rom_addr, 0);
    chk("abort_xyc", {vga_x, vga_y, vga_colour}, 0);
    chk("abort_plot", vga_plot, 0);
    q.delete();
    @(negedge clock);
    #1 resetn = 1;
    repeat (300) @(negedge clock);
    chk("no_done_after_abort", done_cnt, 5);
    kick(30, 40);
    wait_done(400);
    chk("plots_after_reset", plot_cnt, 256);
    chk("done_count_6", done_cnt, 6);
    repeat (2) @(negedge clock);
    #1 start3 = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("tiny_busy", busy3, int'(eb[k-1]));
      chk("tiny_plot", vga_plot3, int'(ep[k-1]));
      chk("tiny_done", done3, int'(ed[k-1]));
      if (k == 1) chk("tiny_addr", rom_addr3, 0);
      if (k == 3) chk("tiny_xyc", {vga_x3, vga_y3, vga_colour3}, 26'h05A);
      #1 start3 = 0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
